// File: rtl/bf_relax_engine_pkg.sv
// bf_pkg: shared FSM encoding and saturating distance arithmetic
// for the Bellman-Ford relaxation engine.
package bf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RELAX,
    CHECK,
    DETECT,
    DONE
  } state_e;

  localparam int XW = 64;

  function automatic logic signed [XW-1:0] inf_of(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [XW-1:0] min_of(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

  // INF is absorbing; finite sums clamp below INF so they never read as "no path".
  function automatic logic signed [XW-1:0] sat_add(
    input logic signed [XW-1:0] a,
    input logic signed [XW-1:0] b,
    input int                   dw
  );
    logic signed [XW-1:0] s;
    if (a == inf_of(dw) || b == inf_of(dw)) return inf_of(dw);
    s = a + b;
    if (s > inf_of(dw) - 64'sd1) return inf_of(dw) - 64'sd1;
    if (s < min_of(dw)) return min_of(dw);
    return s;
  endfunction

endpackage

// File: rtl/bf_relax_engine_if.sv
// bf_relax_engine_if: host load / start / readback bundle
// between the controller (master) and one engine tile (slave).
interface bf_relax_engine_if
  import bf_pkg::*;
#(
  parameter int N        = 8,
  parameter int DW       = 32,
  parameter int MAX_ITER = N - 1
);
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(MAX_ITER + 2);

  logic                 w_we;
  logic [AW-1:0]        w_row;
  logic [N*DW-1:0]      w_data;
  logic                 start;
  logic [AW-1:0]        src;
  logic                 busy;
  logic                 done;
  logic                 early_exit;
  logic                 neg_cycle;
  logic [CW-1:0]        iter_count;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data;

  modport master (
    output w_we, w_row, w_data, start, src, rd_addr,
    input  busy, done, early_exit, neg_cycle,
    input  iter_count, rd_data
  );

  modport slave (
    input  w_we, w_row, w_data, start, src, rd_addr,
    output busy, done, early_exit, neg_cycle,
    output iter_count, rd_data
  );

endinterface

// File: rtl/bf_relax_engine_min_tree.sv
// bf_min_tree: N-input combinational signed minimum,
// log2(N) levels, padded to a power of two with the max value.
module bf_min_tree #(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic signed [DW-1:0] in_i [N],
  output logic signed [DW-1:0] min_o
);
  localparam int L = $clog2(N);
  localparam int P = 1 << L;
  localparam logic signed [DW-1:0] PAD = {1'b0, {(DW-1){1'b1}}};

  logic signed [DW-1:0] t [P];

  always_comb begin
    for (int k = 0; k < P; k++) t[k] = PAD;
    for (int k = 0; k < N; k++) t[k] = in_i[k];
    for (int l = 0; l < L; l++) begin
      for (int k = 0; k < (P >> (l + 1)); k++) begin
        t[k] = (t[2*k+1] < t[2*k]) ? t[2*k+1] : t[2*k];
      end
    end
    min_o = t[0];
  end

endmodule

// File: rtl/bf_relax_engine.sv
// bf_relax_engine: N-node in-place Bellman-Ford sweeps with early exit.
// Define NEG_CYCLE_DETECT_EN to add the post-cap DETECT pass.
module bf_relax_engine
  import bf_pkg::*;
#(
  parameter int N        = 8,
  parameter int DW       = 32,
  parameter int MAX_ITER = N - 1
) (
  input logic clk,
  input logic rst_global,
  bf_relax_engine_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(MAX_ITER + 2);
  localparam logic signed [DW-1:0] INF = DW'(inf_of(DW));
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [CW-1:0] ITER_MAX = CW'(MAX_ITER);

  state_e state_q, state_d;
  logic [AW-1:0] col_q, col_d;
  logic [AW-1:0] src_q;
  logic [CW-1:0] iter_q, iter_d;
  logic chg_q, chg_d;
  logic early_q, early_d;
  logic neg_q, neg_d;

  logic signed [DW-1:0] w_q [N][N];
  logic signed [DW-1:0] d_q [N];
  logic signed [DW-1:0] sum [N];
  logic signed [DW-1:0] cand;

  logic better, start_acc, w_wr;
  logic d_init, d_we;

  // Candidate path into the current column from every node.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      sum[i] = DW'(sat_add(XW'(d_q[i]), XW'(w_q[i][col_q]), DW));
    end
  end

  bf_min_tree #(
    .N  (N),
    .DW (DW)
  ) u_min (
    .in_i  (sum),
    .min_o (cand)
  );

  assign better    = cand < d_q[col_q];
  assign start_acc = (state_q == IDLE) && bus.start;
  assign w_wr      = bus.w_we && !bus.busy;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    iter_d  = iter_q;
    chg_d   = chg_q;
    early_d = early_q;
    neg_d   = neg_q;
    d_init  = 1'b0;
    d_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = INIT;
      end
      INIT: begin
        d_init  = 1'b1;
        iter_d  = '0;
        chg_d   = 1'b0;
        early_d = 1'b0;
        neg_d   = 1'b0;
        col_d   = '0;
        state_d = RELAX;
      end
      RELAX: begin
        if (better) begin
          d_we  = 1'b1;
          chg_d = 1'b1;
        end
        col_d = col_q + AW'(1);
        if (col_q == LAST) begin
          col_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        iter_d = iter_q + CW'(1);
        if (!chg_q) begin
          early_d = 1'b1;
          state_d = DONE;
        end else if (iter_d == ITER_MAX) begin
`ifdef NEG_CYCLE_DETECT_EN
          state_d = DETECT;
`else
          state_d = DONE;
`endif
        end else begin
          chg_d   = 1'b0;
          state_d = RELAX;
        end
      end
`ifdef NEG_CYCLE_DETECT_EN
      DETECT: begin
        if (better) neg_d = 1'b1;
        col_d = col_q + AW'(1);
        if (col_q == LAST) begin
          col_d   = '0;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_global) begin
      state_q <= IDLE;
      col_q   <= '0;
      src_q   <= '0;
      iter_q  <= '0;
      chg_q   <= 1'b0;
      early_q <= 1'b0;
      neg_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        d_q[i] <= INF;
        for (int j = 0; j < N; j++) w_q[i][j] <= INF;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      iter_q  <= iter_d;
      chg_q   <= chg_d;
      early_q <= early_d;
      neg_q   <= neg_d;
      if (start_acc) src_q <= bus.src;
      if (w_wr) begin
        for (int j = 0; j < N; j++) begin
          w_q[bus.w_row][j] <= bus.w_data[j*DW +: DW];
        end
      end
      if (d_init) begin
        for (int i = 0; i < N; i++) begin
          d_q[i] <= (AW'(i) == src_q) ? '0 : INF;
        end
      end else if (d_we) begin
        d_q[col_q] <= cand;
      end
    end
  end

  assign bus.busy = (state_q == INIT) || (state_q == RELAX)
                 || (state_q == CHECK) || (state_q == DETECT);
  assign bus.done       = (state_q == DONE);
  assign bus.early_exit = early_q;
`ifdef NEG_CYCLE_DETECT_EN
  assign bus.neg_cycle  = neg_q;
`else
  assign bus.neg_cycle  = 1'b0;
`endif
  assign bus.iter_count = iter_q;
  assign bus.rd_data    = d_q[bus.rd_addr];

endmodule
